// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared widths, EX/MEM record and data-memory FSM state encoding.
// Rev    : 1.0
// ============================================================================
package cpu_types_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 5;

  typedef logic [CPU_DATA_W-1:0] word_t;
  typedef logic [CPU_REG_AW-1:0] regbits_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic        memtoReg;
    logic        memWr;
    logic        RegWr;
    logic        halt;
    regbits_t    wsel;
    word_t       aluout;
    word_t       busB;
    word_t       imemaddr;
    logic [31:0] instr;
  } ex_mem_t;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_req_fsm.sv
`default_nettype none
// ============================================================================
// Module : dmem_req_fsm
// Brief  : Data-cache request sequencer; owns state and deferred flush.
// Rev    : 1.0
// ============================================================================
module dmem_req_fsm
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic enable_i,
  input  logic flush_i,
  input  logic dhit_i,
  input  logic memtoReg_EX_i,
  input  logic memWr_EX_i,
  input  logic memtoReg_MEM_i,
  input  logic memWr_MEM_i,
  input  logic halt_MEM_i,
  output logic busy_o,
  output logic dmemREN_o,
  output logic dmemWEN_o,
  output logic load_o,
  output logic clear_o,
  output logic capture_o
);

  mem_state_t state_q, state_d;
  logic       pend_flush_q, pend_flush_d;
  logic       in_req;
  logic       flush_req;
  logic       load;
  mem_state_t load_state;

  assign in_req    = (state_q == REQ);
  assign busy_o    = in_req && !dhit_i;
  assign flush_req = flush_i || pend_flush_q;
  assign load      = enable_i && !busy_o && !flush_i && !pend_flush_q;
  assign dmemREN_o = in_req && memtoReg_MEM_i;
  assign dmemWEN_o = in_req && memWr_MEM_i;
  assign load_o    = load;

  // A halted pipeline never starts another cache access.
  assign load_state = (is_mem_op(memtoReg_EX_i, memWr_EX_i) && !halt_MEM_i) ? REQ : IDLE;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    clear_o      = 1'b0;
    capture_o    = 1'b0;
    case (state_q)
      REQ: begin
        if (dhit_i) begin
          pend_flush_d = 1'b0;
          if (flush_req) begin
            clear_o = 1'b1;
            state_d = IDLE;
          end else begin
            capture_o = memtoReg_MEM_i;
            state_d   = load ? load_state : DONE;
          end
        end else begin
          pend_flush_d = flush_req;
        end
      end
      default: begin
        if (flush_i) begin
          clear_o = 1'b1;
          state_d = IDLE;
        end else if (load) begin
          state_d = load_state;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/execute_memory.sv
`default_nettype none
// ============================================================================
// Module : execute_memory
// Brief  : EX/MEM pipeline latch with data-cache request/hold handshake.
// Rev    : 1.0
// ============================================================================
module execute_memory
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enable,
  input  logic              flush,
  input  logic              memtoReg_EX,
  input  logic              memWr_EX,
  input  logic              RegWr_EX,
  input  logic [REG_AW-1:0] wsel_EX,
  input  logic              halt_EX,
  input  logic [DATA_W-1:0] aluout_EX,
  input  logic [DATA_W-1:0] busB_EX,
  input  logic [DATA_W-1:0] imemaddr_EX,
  input  logic [31:0]       instr_EX,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              memtoReg_MEM,
  output logic              memWr_MEM,
  output logic              RegWr_MEM,
  output logic              halt_MEM,
  output logic [REG_AW-1:0] wsel_MEM,
  output logic [DATA_W-1:0] aluout_MEM,
  output logic [DATA_W-1:0] busB_MEM,
  output logic [DATA_W-1:0] imemaddr_MEM,
  output logic [DATA_W-1:0] lddata_MEM,
  output logic [31:0]       instr_MEM
);

  ex_mem_t ex_in;
  ex_mem_t mem_q, mem_d;
  word_t   lddata_q, lddata_d;
  logic    busy, load, clear, capture;

  dmem_req_fsm u_fsm (
    .CLK            (CLK),
    .nRST           (nRST),
    .enable_i       (enable),
    .flush_i        (flush),
    .dhit_i         (dhit),
    .memtoReg_EX_i  (memtoReg_EX),
    .memWr_EX_i     (memWr_EX),
    .memtoReg_MEM_i (mem_q.memtoReg),
    .memWr_MEM_i    (mem_q.memWr),
    .halt_MEM_i     (mem_q.halt),
    .busy_o         (busy),
    .dmemREN_o      (dmemREN),
    .dmemWEN_o      (dmemWEN),
    .load_o         (load),
    .clear_o        (clear),
    .capture_o      (capture)
  );

  always_comb begin
    ex_in.memtoReg = memtoReg_EX;
    ex_in.memWr    = memWr_EX;
    ex_in.RegWr    = RegWr_EX;
    ex_in.halt     = halt_EX;
    ex_in.wsel     = wsel_EX;
    ex_in.aluout   = aluout_EX;
    ex_in.busB     = busB_EX;
    ex_in.imemaddr = imemaddr_EX;
    ex_in.instr    = instr_EX;
  end

  // halt survives both clears and loads; only reset drops it.
  always_comb begin
    mem_d    = mem_q;
    lddata_d = lddata_q;
    if (clear) begin
      mem_d      = '0;
      mem_d.halt = mem_q.halt;
      lddata_d   = '0;
    end else if (load) begin
      mem_d      = ex_in;
      mem_d.halt = mem_q.halt | halt_EX;
      lddata_d   = capture ? dmemload : '0;
    end else if (capture) begin
      lddata_d = dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_q    <= '0;
      lddata_q <= '0;
    end else begin
      mem_q    <= mem_d;
      lddata_q <= lddata_d;
    end
  end

  assign mem_stall    = busy;
  assign dmemaddr     = mem_q.aluout;
  assign dmemstore    = mem_q.busB;
  assign memtoReg_MEM = mem_q.memtoReg;
  assign memWr_MEM    = mem_q.memWr;
  assign RegWr_MEM    = mem_q.RegWr;
  assign halt_MEM     = mem_q.halt;
  assign wsel_MEM     = mem_q.wsel;
  assign aluout_MEM   = mem_q.aluout;
  assign busB_MEM     = mem_q.busB;
  assign imemaddr_MEM = mem_q.imemaddr;
  assign instr_MEM    = mem_q.instr;
  assign lddata_MEM   = lddata_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_memory.sv
`default_nettype none
// ============================================================================
// Module : tb_execute_memory
// Brief  : Scoreboard bench for execute_memory against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_execute_memory;

  typedef struct packed {
    logic        mtr;
    logic        mwr;
    logic        rw;
    logic        halt;
    logic [4:0]  wsel;
    logic [31:0] alu;
    logic [31:0] busB;
    logic [31:0] imem;
    logic [31:0] instr;
  } ex_t;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] store;
    ex_t         post;
    logic [31:0] ld;
  } exp_t;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        enable = 1'b0, flush = 1'b0, dhit = 1'b0;
  logic        memtoReg_EX = 1'b0, memWr_EX = 1'b0, RegWr_EX = 1'b0, halt_EX = 1'b0;
  logic [4:0]  wsel_EX = '0;
  logic [31:0] aluout_EX = '0, busB_EX = '0, imemaddr_EX = '0, instr_EX = '0, dmemload = '0;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        memtoReg_MEM, memWr_MEM, RegWr_MEM, halt_MEM;
  logic [4:0]  wsel_MEM;
  logic [31:0] aluout_MEM, busB_MEM, imemaddr_MEM, lddata_MEM, instr_MEM;

  execute_memory dut (
    .CLK(clk), .nRST(nRST), .enable(enable), .flush(flush),
    .memtoReg_EX(memtoReg_EX), .memWr_EX(memWr_EX), .RegWr_EX(RegWr_EX),
    .wsel_EX(wsel_EX), .halt_EX(halt_EX), .aluout_EX(aluout_EX), .busB_EX(busB_EX),
    .imemaddr_EX(imemaddr_EX), .instr_EX(instr_EX), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .memtoReg_MEM(memtoReg_MEM), .memWr_MEM(memWr_MEM),
    .RegWr_MEM(RegWr_MEM), .halt_MEM(halt_MEM), .wsel_MEM(wsel_MEM),
    .aluout_MEM(aluout_MEM), .busB_MEM(busB_MEM), .imemaddr_MEM(imemaddr_MEM),
    .lddata_MEM(lddata_MEM), .instr_MEM(instr_MEM)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  // Reference model: latched instruction, load data, and whether an access
  // is still waiting for the cache / has a squash queued behind it.
  ex_t         m;
  logic [31:0] m_ld;
  bit          m_out;
  bit          m_kill;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m      = '0;
    m_ld   = '0;
    m_out  = 1'b0;
    m_kill = 1'b0;
  endtask

  // One clock of stimulus: starts and ends on a falling edge.
  task automatic drive(input ex_t e, input bit en, input bit fl, input bit hit, input logic [31:0] ld);
    exp_t x;
    bit   h;
    logic [31:0] newld;
    enable = en; flush = fl; dhit = hit; dmemload = ld;
    memtoReg_EX = e.mtr; memWr_EX = e.mwr; RegWr_EX = e.rw; halt_EX = e.halt;
    wsel_EX = e.wsel; aluout_EX = e.alu; busB_EX = e.busB;
    imemaddr_EX = e.imem; instr_EX = e.instr;

    x.ren   = m_out && m.mtr;
    x.wen   = m_out && m.mwr;
    x.stall = m_out && !hit;
    x.addr  = m.alu;
    x.store = m.busB;

    if (m_out && !hit) begin
      m_kill = m_kill | fl;
    end else if ((m_out && (fl || m_kill)) || (!m_out && fl)) begin
      h      = m.halt;
      m      = '0;
      m.halt = h;
      m_ld   = '0;
      m_out  = 1'b0;
      m_kill = 1'b0;
    end else begin
      if (m_out && m.mtr) m_ld = ld;
      if (en) begin
        h      = m.halt;
        newld  = (m_out && m.mtr) ? ld : 32'h0;
        m_out  = (e.mtr || e.mwr) && !h;
        m      = e;
        m.halt = h | e.halt;
        m_ld   = newld;
      end else begin
        m_out = 1'b0;
      end
      m_kill = 1'b0;
    end

    x.post = m;
    x.ld   = m_ld;
    sb.push_back(x);
    @(negedge clk);
    cyc++;
  endtask

  function automatic ex_t mk(input bit mtr, input bit mwr, input bit rw, input bit hlt,
                             input logic [4:0] ws, input logic [31:0] alu, input logic [31:0] bb);
    ex_t e;
    e.mtr = mtr; e.mwr = mwr; e.rw = rw; e.halt = hlt; e.wsel = ws;
    e.alu = alu; e.busB = bb; e.imem = alu + 32'd4; e.instr = {alu[15:0], bb[15:0]};
    return e;
  endfunction

  function automatic ex_t rand_ex(input bit allow_halt);
    ex_t e;
    int  k;
    k = $urandom_range(0, 99);
    e.mtr   = (k < 30);
    e.mwr   = (k >= 30) && (k < 55);
    e.halt  = allow_halt && (k == 99);
    e.rw    = 1'($urandom_range(0, 1));
    e.wsel  = 5'($urandom_range(0, 31));
    e.alu   = $urandom();
    e.busB  = $urandom();
    e.imem  = $urandom();
    e.instr = $urandom();
    return e;
  endfunction

  task automatic do_reset();
    enable = 0; flush = 0; dhit = 0; memtoReg_EX = 0; memWr_EX = 0; halt_EX = 0;
    nRST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
  endtask

  // Monitor: combinational request outputs late in the cycle, registered
  // outputs just after the rising edge, then compare against the queue head.
  initial begin : monitor
    exp_t        x;
    logic        s_ren, s_wen, s_stall;
    logic [31:0] s_addr, s_store;
    forever begin
      @(negedge clk);
      #3;
      s_ren = dmemREN; s_wen = dmemWEN; s_stall = mem_stall;
      s_addr = dmemaddr; s_store = dmemstore;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("dmemREN", 32'(s_ren), 32'(x.ren));
        chk("dmemWEN", 32'(s_wen), 32'(x.wen));
        chk("mem_stall", 32'(s_stall), 32'(x.stall));
        if (x.ren || x.wen) chk("dmemaddr", s_addr, x.addr);
        if (x.wen) chk("dmemstore", s_store, x.store);
        chk("memtoReg_MEM", 32'(memtoReg_MEM), 32'(x.post.mtr));
        chk("memWr_MEM", 32'(memWr_MEM), 32'(x.post.mwr));
        chk("RegWr_MEM", 32'(RegWr_MEM), 32'(x.post.rw));
        chk("halt_MEM", 32'(halt_MEM), 32'(x.post.halt));
        chk("wsel_MEM", 32'(wsel_MEM), 32'(x.post.wsel));
        chk("aluout_MEM", aluout_MEM, x.post.alu);
        chk("busB_MEM", busB_MEM, x.post.busB);
        chk("imemaddr_MEM", imemaddr_MEM, x.post.imem);
        chk("instr_MEM", instr_MEM, x.post.instr);
        chk("lddata_MEM", lddata_MEM, x.ld);
      end
    end
  end

  initial begin : stimulus
    ex_t nop;
    nop = '0;
    model_reset();
    @(negedge clk);
    chk("reset_REN", 32'(dmemREN), 32'h0);
    chk("reset_aluout", aluout_MEM, 32'h0);
    chk("reset_lddata", lddata_MEM, 32'h0);
    @(negedge clk);
    nRST = 1'b1;

    // Load with three wait cycles, then hit.
    drive(mk(1, 0, 1, 0, 5'd3, 32'h40, 32'h0), 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) drive(rand_ex(0), 1, 0, 0, $urandom());
    drive(nop, 0, 0, 1, 32'hDEAD_BEEF);
    chk("load_lddata", lddata_MEM, 32'hDEAD_BEEF);
    chk("load_REN_after", 32'(dmemREN), 32'h0);

    // Store with same-cycle hit.
    drive(mk(0, 1, 0, 0, 5'd0, 32'h80, 32'h1234_5678), 1, 0, 0, 32'h0);
    chk("store_dmemstore", dmemstore, 32'h1234_5678);
    chk("store_WEN", 32'(dmemWEN), 32'h1);
    drive(nop, 0, 0, 1, 32'hFFFF_FFFF);
    chk("store_lddata", lddata_MEM, 32'h0);
    chk("store_WEN_after", 32'(dmemWEN), 32'h0);

    // Flush while a load is waiting.
    drive(mk(1, 0, 1, 0, 5'd9, 32'h100, 32'h0), 1, 0, 0, 32'h0);
    drive(nop, 1, 1, 0, 32'h0);
    drive(rand_ex(0), 1, 0, 0, 32'h0);
    chk("flush_REN_held", 32'(dmemREN), 32'h1);
    drive(rand_ex(0), 1, 0, 1, 32'hCAFE_F00D);
    chk("flush_aluout", aluout_MEM, 32'h0);
    chk("flush_REN_after", 32'(dmemREN), 32'h0);

    // Hold, then plain flush.
    drive(mk(0, 0, 1, 0, 5'd5, 32'h7, 32'h0), 1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) drive(rand_ex(0), 0, 0, 0, 32'h0);
    chk("hold_wsel", 32'(wsel_MEM), 32'd5);
    chk("hold_aluout", aluout_MEM, 32'd7);
    drive(rand_ex(0), 1, 1, 0, 32'h0);
    chk("flush_RegWr", 32'(RegWr_MEM), 32'h0);
    chk("flush_wsel", 32'(wsel_MEM), 32'h0);

    // Halt is sticky and suppresses later requests.
    drive(mk(0, 0, 0, 1, 5'd0, 32'h0, 32'h0), 1, 0, 0, 32'h0);
    drive(nop, 1, 1, 0, 32'h0);
    drive(mk(1, 0, 1, 0, 5'd2, 32'h44, 32'h0), 1, 0, 0, 32'h0);
    chk("halt_sticky", 32'(halt_MEM), 32'h1);
    chk("halt_no_REN", 32'(dmemREN), 32'h0);
    drive(nop, 0, 0, 1, 32'h1);

    // Asynchronous reset in the middle of an outstanding load.
    do_reset();
    drive(mk(1, 0, 1, 0, 5'd4, 32'h200, 32'h0), 1, 0, 0, 32'h0);
    drive(nop, 0, 0, 0, 32'h0);
    #1;
    chk("midload_REN_before", 32'(dmemREN), 32'h1);
    #1;
    nRST = 1'b0;
    #1;
    chk("midload_REN_reset", 32'(dmemREN), 32'h0);
    chk("midload_stall_reset", 32'(mem_stall), 32'h0);
    chk("midload_aluout_reset", aluout_MEM, 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
    drive(nop, 0, 0, 0, 32'h0);

    // Randomised phases, each from reset.
    for (int p = 0; p < 4; p++) begin
      do_reset();
      for (int i = 0; i < 200; i++)
        drive(rand_ex(p == 3), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 9) < 4), $urandom());
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_memory.md
Name: execute_memory

Overview:
- EX/MEM pipeline register, directly downstream of the decode/execute latch.
- Captures EX-stage results and control signals.
- Drives the data-cache request interface and holds each load/store request until dhit.
- Asserts mem_stall back to the hazard unit while an access is outstanding.
- Presents registered results, and registered load data, to the memory/writeback latch.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
enable  in  1  hazard-unit advance permission
flush  in  1  squash current EX/MEM contents
memtoReg_EX  in  1  instruction is a load
memWr_EX  in  1  instruction is a store
RegWr_EX  in  1  register write enable
wsel_EX  in  REG_AW  destination register
halt_EX  in  1  halt instruction
aluout_EX  in  DATA_W  ALU result / memory address
busB_EX  in  DATA_W  store data
imemaddr_EX  in  DATA_W  PC+4 (link value)
instr_EX  in  32  instruction word
dhit  in  1  cache access complete
dmemload  in  DATA_W  cache read data
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  DATA_W  cache address (= aluout_MEM)
dmemstore  out  DATA_W  cache write data (= busB_MEM)
mem_stall  out  1  access outstanding, freeze upstream
memtoReg_MEM, memWr_MEM, RegWr_MEM, halt_MEM  out  1 each  registered controls
wsel_MEM  out  REG_AW  registered destination
aluout_MEM, busB_MEM, imemaddr_MEM, lddata_MEM  out  DATA_W each  registered data
instr_MEM  out  32  registered instruction

Behaviour:
- Reset (nRST low, asynchronous):
  - every *_MEM output and lddata_MEM cleared to 0.
  - FSM in IDLE; pend_flush = 0; dmemREN = dmemWEN = mem_stall = 0.
- FSM states:
  - IDLE: no memory op held.
  - REQ: request outstanding.
  - DONE: access complete, result held.
- Busy term: busy = (state == REQ) && !dhit. mem_stall = busy (combinational, same-cycle).
- dmemREN = (state == REQ) && memtoReg_MEM. dmemWEN = (state == REQ) && memWr_MEM. Both are 0 in IDLE and DONE.
- The request is never dropped before dhit. dmemaddr and dmemstore stay stable throughout REQ.
- Load condition: enable && !busy && !flush && !pend_flush.
  - All *_MEM registers take the *_EX values.
  - Next state = REQ if memtoReg_EX or memWr_EX, else IDLE.
  - lddata_MEM cleared to 0.
- In REQ with dhit and no load this cycle:
  - lddata_MEM <= dmemload when memtoReg_MEM.
  - state -> DONE.
- In REQ with dhit and enable:
  - dhit completes the current access and the load condition applies in the same edge.
  - Load data is forwarded through the combinational path. The downstream latch samples dmemload via lddata_MEM only when DONE is passed through, so the hazard unit must deassert enable on a dhit cycle. If enable is high anyway, lddata_MEM still captures dmemload before the new contents replace the register.
- Hold: enable low and not busy → all registers keep their values; state unchanged.
- Flush when state != REQ:
  - all *_MEM registers and lddata_MEM cleared to 0; state -> IDLE.
  - Flush has priority over enable.
- Flush when state == REQ:
  - the outstanding access must finish; pend_flush is set.
  - On dhit, registers are cleared, state -> IDLE, pend_flush cleared.
  - mem_stall stays asserted until dhit.
- halt_MEM is sticky: once 1, it stays 1 until reset regardless of flush or load. No new cache request is issued after halt_MEM = 1.
- Store completion: a dhit in REQ with memWr_MEM only moves to DONE. lddata_MEM is unchanged.
- Reset asserted mid-REQ aborts immediately. The request outputs drop asynchronously.

Decomposition:
- Shared package cpu_types_pkg:
  - mem_state_t enum {IDLE, REQ, DONE}
  - word_t (DATA_W)
  - regbits_t (REG_AW)
  - ex_mem_t struct bundling the latched control/data fields
- Sub-module dmem_req_fsm owns state and pend_flush. It generates busy, dmemREN, dmemWEN and the capture/clear strobes. The top level holds the registers.

Test Plan:
- Reset mid-load: REN high in REQ, nRST low → dmemREN = 0 immediately; all outputs 0; state IDLE after release.
- Load, 3-cycle dhit latency: memtoReg_EX = 1, aluout_EX = 0x0000_0040, enable = 1 →
  - dmemREN = 1 and dmemaddr = 0x40 for 3 cycles; mem_stall = 1 on those cycles.
  - dhit with dmemload = 0xDEAD_BEEF → lddata_MEM = 0xDEADBEEF; state DONE; REN = 0.
- Store, 1-cycle hit: memWr_EX = 1, busB_EX = 0x1234_5678, aluout_EX = 0x80 →
  - WEN = 1 for one cycle; dmemstore = 0x12345678; dhit same cycle → mem_stall never high; lddata_MEM unchanged.
- Flush during REQ: flush pulsed while waiting; dhit two cycles later →
  - REN held until dhit; then all *_MEM = 0 and state IDLE on the next edge.
- Hold and plain flush: non-memory instruction latched (RegWr = 1, wsel = 5, aluout = 7); enable = 0 for 4 cycles →
  - values unchanged.
  - Then flush = 1 with enable = 1 → everything 0; new EX values ignored.
- Halt sticky: halt_EX = 1 latched; then flush and a load instruction presented →
  - halt_MEM remains 1; dmemREN stays 0.
